// File: rtl/stack_display_pkg.sv
// rtl/stack_display_pkg.sv - shared constants, segment decoder and FSM encoding
package stack_display_pkg;

  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Segment order {A,B,C,D,E,F,G}; non-decimal nibbles never reach here but render as dash.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_to_seg = 7'b1111110;
      4'd1:    digit_to_seg = 7'b0110000;
      4'd2:    digit_to_seg = 7'b1101101;
      4'd3:    digit_to_seg = 7'b1111001;
      4'd4:    digit_to_seg = 7'b0110011;
      4'd5:    digit_to_seg = 7'b1011011;
      4'd6:    digit_to_seg = 7'b1011111;
      4'd7:    digit_to_seg = 7'b1110000;
      4'd8:    digit_to_seg = 7'b1111111;
      4'd9:    digit_to_seg = 7'b1111011;
      default: digit_to_seg = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/stack_display_if.sv
// rtl/stack_display_if.sv - stack word input and multiplexed display output bundle
interface stack_display_if #(
  parameter int VALUE_W = 32,
  parameter int DIGITS  = 4
);
  logic [VALUE_W-1:0] value;
  logic               valid;
  logic [6:0]         seg;
  logic [DIGITS-1:0]  digit_sel;
  logic               busy;

  modport master (output value, valid, input seg, digit_sel, busy);
  modport slave  (input value, valid, output seg, digit_sel, busy);
endinterface

// File: rtl/stack_display_bin2bcd_serial.sv
// rtl/stack_display_bin2bcd_serial.sv - serial shift-add-3 binary to BCD converter
module bin2bcd_serial #(
  parameter int VALUE_W = 32,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    din,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0]  bin_q;
  logic [CW-1:0]       cnt_q;
  logic [4*DIGITS-1:0] bcd_adj;

  // Add 3 to every nibble >= 5 so the following shift carries correctly into the next digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // High during the last shift cycle, so the result is final on the following cycle.
  assign done = (cnt_q == CW'(1));

  // Capture on start, then one adjust-and-shift per cycle; a bit leaving the top digit means overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      bin_q    <= din;
      bcd      <= '0;
      overflow <= 1'b0;
      cnt_q    <= CW'(VALUE_W);
    end else if (cnt_q != '0) begin
      {bcd, bin_q} <= {bcd_adj[4*DIGITS-2:0], bin_q, 1'b0};
      if (bcd_adj[4*DIGITS-1]) overflow <= 1'b1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/stack_display.sv
// rtl/stack_display.sv - top-of-stack decimal display driver with atomic commit and digit scanner
module stack_display
  import stack_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int VALUE_W  = 32,
  parameter int SCAN_DIV = 14
) (
  input  logic           clk,
  input  logic           rst,
  stack_display_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                    state_q, state_d;
  logic                      start, drop;
  logic [VALUE_W-1:0]        last_value_q;
  logic                      last_valid_q;
  logic                      dash_pend_q;
  logic                      conv_done, conv_ovf;
  logic [4*DIGITS-1:0]       conv_bcd;
  logic [DIGITS-1:0][6:0]    disp_buf;
  logic [DIGITS-1:0][6:0]    commit_pat;
  logic                      leading;
  logic [SCAN_DIV-1:0]       presc_q;
  logic [IW-1:0]             idx_q, idx_d;

  bin2bcd_serial #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din      (bus.value),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Inputs are only looked at in IDLE, so whatever is current when we get back there wins.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid && (bus.value != last_value_q || !last_valid_q)) begin
          start   = 1'b1;
          state_d = CONVERT;
        end else if (!bus.valid && last_valid_q) begin
          drop = 1'b1;
        end
      end
      CONVERT: if (conv_done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Remember what is shown; an emptied stack schedules an all-dash load for the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_value_q <= '0;
      last_valid_q <= 1'b0;
      dash_pend_q  <= 1'b0;
    end else begin
      if (start) begin
        last_value_q <= bus.value;
        last_valid_q <= 1'b1;
      end else if (drop) begin
        last_valid_q <= 1'b0;
      end
      dash_pend_q <= drop;
    end
  end

  // Overflow dashes everything; otherwise blank leading zeros but always show digit 0.
  always_comb begin
    commit_pat = '0;
    leading    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (conv_ovf) begin
        commit_pat[i] = SEG_DASH;
      end else begin
        if (conv_bcd[4*i +: 4] != 4'd0 || i == 0) leading = 1'b0;
        commit_pat[i] = leading ? SEG_BLANK : digit_to_seg(conv_bcd[4*i +: 4]);
      end
    end
  end

  // Display buffer changes only as a whole, so no half-converted value is ever visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    disp_buf <= {DIGITS{SEG_DASH}};
    else if (state_q == COMMIT) disp_buf <= commit_pat;
    else if (dash_pend_q)       disp_buf <= {DIGITS{SEG_DASH}};
  end

  // Next digit index: advance on prescaler wrap and wrap explicitly at the last digit.
  always_comb begin
    idx_d = idx_q;
    if (presc_q == '1) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  // Scanner outputs are registered together so seg and digit_sel switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      bus.seg       <= SEG_DASH;
      bus.digit_sel <= DIGITS'(1);
    end else begin
      presc_q       <= presc_q + SCAN_DIV'(1);
      idx_q         <= idx_d;
      bus.seg       <= disp_buf[idx_d];
      bus.digit_sel <= DIGITS'(1) << idx_d;
    end
  end

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_stack_display.sv
// tb/tb_stack_display.sv - directed vector bench for stack_display
module tb_stack_display;

  localparam logic [6:0] DSH = 7'b0000001;
  localparam logic [6:0] BLK = 7'b0000000;
  localparam logic [6:0] S0  = 7'b1111110;
  localparam logic [6:0] S1  = 7'b0110000;
  localparam logic [6:0] S2  = 7'b1101101;
  localparam logic [6:0] S3  = 7'b1111001;
  localparam logic [6:0] S4  = 7'b0110011;
  localparam logic [6:0] S5  = 7'b1011011;
  localparam logic [6:0] S7  = 7'b1110000;
  localparam logic [6:0] S9  = 7'b1111011;

  typedef logic [3:0][6:0] disp_t;
  typedef struct {
    logic [31:0] value;
    disp_t       exp;
  } vec_t;

  localparam disp_t ALL_DASH = {DSH, DSH, DSH, DSH};
  localparam disp_t PAT5     = {BLK, BLK, BLK, S5};
  localparam disp_t PAT42    = {BLK, BLK, S4, S2};
  localparam disp_t PAT3     = {BLK, BLK, BLK, S3};

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  disp_t seen;
  int    hits [4];
  vec_t  vecs [8];

  always #5 clk = ~clk;

  stack_display_if #(.VALUE_W(32), .DIGITS(4)) bus ();

  stack_display #(
    .DIGITS   (4),
    .VALUE_W  (32),
    .SCAN_DIV (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full scan period (4 digits x 4 cycles), recording the pattern shown per digit.
  task automatic scan_display();
    seen = 'x;
    for (int d = 0; d < 4; d++) hits[d] = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (bus.digit_sel == 4'(1 << d)) begin
          seen[d] = bus.seg;
          hits[d]++;
        end
      end
    end
  endtask

  task automatic check_display(input string name, input disp_t exp);
    scan_display();
    for (int d = 0; d < 4; d++) check($sformatf("%s_seg%0d", name, d), 32'(seen[d]), 32'(exp[d]));
  endtask

  // Wait (bounded) for busy to rise, then count the cycles it stays high.
  task automatic run_conversion(output int len);
    int guard;
    len   = 0;
    guard = 0;
    while (bus.busy !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    while (bus.busy === 1'b1 && len < 60) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int    len;
    int    guard;
    int    nch;
    disp_t prev;
    disp_t ch [4];

    vecs[0] = '{32'd7,          {BLK, BLK, BLK, S7}};
    vecs[1] = '{32'd1234,       {S1, S2, S3, S4}};
    vecs[2] = '{32'd9999,       {S9, S9, S9, S9}};
    vecs[3] = '{32'd10000,      ALL_DASH};
    vecs[4] = '{32'd0,          {BLK, BLK, BLK, S0}};
    vecs[5] = '{32'd305,        {BLK, S3, S0, S5}};
    vecs[6] = '{32'd99,         {BLK, BLK, S9, S9}};
    vecs[7] = '{32'hFFFF_FFFF,  ALL_DASH};

    rst       = 1'b1;
    bus.valid = 1'b0;
    bus.value = '0;
    @(negedge clk);
    check("rst_seg", 32'(bus.seg), 32'(DSH));
    check("rst_sel", 32'(bus.digit_sel), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_display("idle_empty", ALL_DASH);
    check("idle_empty_busy", 32'(bus.busy), 32'h0);

    for (int i = 0; i < 8; i++) begin
      bus.value = vecs[i].value;
      bus.valid = 1'b1;
      run_conversion(len);
      check($sformatf("v%0d_busy_len", i), 32'(len), 32'd33);
      repeat (2) @(negedge clk);
      check_display($sformatf("v%0d", i), vecs[i].exp);
      for (int d = 0; d < 4; d++) check($sformatf("v%0d_sel%0d_cycles", i, d), 32'(hits[d]), 32'd4);
    end

    // value changes on the 10th CONVERT cycle: 5 commits first, then 42, nothing else.
    bus.value = 32'd5;
    guard = 0;
    while (bus.busy !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check("chg_busy_start", 32'(bus.busy), 32'h1);
    prev = dut.disp_buf;
    nch  = 0;
    for (int c = 1; c <= 90; c++) begin
      if (c == 10) bus.value = 32'd42;
      @(negedge clk);
      if (dut.disp_buf !== prev) begin
        if (nch < 4) ch[nch] = dut.disp_buf;
        nch++;
        prev = dut.disp_buf;
      end
    end
    check("chg_count", 32'(nch), 32'd2);
    check("chg_first", 32'(ch[0]), 32'(PAT5));
    check("chg_second", 32'(ch[1]), 32'(PAT42));

    // Stack empties while 42 is shown: dash on the second edge.
    bus.valid = 1'b0;
    @(negedge clk);
    check("empty_edge1", 32'(dut.disp_buf), 32'(PAT42));
    @(negedge clk);
    check("empty_edge2", 32'(dut.disp_buf), 32'(ALL_DASH));
    repeat (3) @(negedge clk);
    bus.valid = 1'b1;
    run_conversion(len);
    check("refill_busy_len", 32'(len), 32'd33);
    repeat (2) @(negedge clk);
    check_display("refill42", PAT42);

    // Reset mid-conversion aborts to reset values, then a fresh conversion of 3.
    bus.value = 32'd3;
    guard = 0;
    while (bus.busy !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_seg", 32'(bus.seg), 32'(DSH));
    check("mid_rst_sel", 32'(bus.digit_sel), 32'h1);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_buf", 32'(dut.disp_buf), 32'(ALL_DASH));
    @(negedge clk);
    rst = 1'b0;
    repeat (33) @(negedge clk);
    check("rerun_edge33_buf", 32'(dut.disp_buf), 32'(ALL_DASH));
    check("rerun_edge33_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("rerun_edge34_buf", 32'(dut.disp_buf), 32'(PAT3));
    check_display("rerun3", PAT3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
